// File: rtl/adc_reader.sv
// adc_reader: dual-channel SPI ADC capture master that turns serial frames into two parallel samples.
// Optional ADC_LEAD_CHECK_EN flags frames whose leading bits above the sample width are nonzero.
module adc_reader #(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_BITS   = 16,
  parameter int DATA_BITS    = 12,
  parameter int QUIET_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 data_in1,
  input  logic                 data_in2,
  output logic                 adc_clk,
  output logic                 chip_sel,
  output logic [DATA_BITS-1:0] data_out1,
  output logic [DATA_BITS-1:0] data_out2,
  output logic                 valid,
  output logic                 ready,
  output logic                 frame_err
);
  localparam int CMAX = CLK_DIV > QUIET_CYCLES ? CLK_DIV : QUIET_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int HW = $clog2(2 * FRAME_BITS + 1);
`ifdef ADC_LEAD_CHECK_EN
  localparam int SW = FRAME_BITS;
`else
  localparam int SW = DATA_BITS;
`endif
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [HW-1:0] r_half, w_half;
  // The bit shifted out of the top is never observed, so one bit less is kept.
  logic [SW-2:0] r_sr1, r_sr2;
  logic [SW-1:0] w_cap1, w_cap2;
  logic [DATA_BITS-1:0] r_d1, r_d2;
  logic r_adc_clk, r_cs, r_valid, r_ready;
  logic w_adc_clk, w_cs, w_valid, w_ready, w_shift;
  assign w_cap1 = {r_sr1, data_in1};
  assign w_cap2 = {r_sr2, data_in2};
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_half    = r_half;
    w_adc_clk = r_adc_clk;
    w_cs      = r_cs;
    w_valid   = 1'b0;
    w_ready   = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = ~go;
        if (go) begin
          w_state = SETUP;
          w_cs    = 1'b0;
          w_cnt   = '0;
          w_half  = '0;
        end
      end
      SETUP: begin
        w_state = r_cnt == CW'(CLK_DIV - 1) ? SHIFT : SETUP;
        w_cnt   = r_cnt == CW'(CLK_DIV - 1) ? '0 : r_cnt + CW'(1);
      end
      SHIFT: begin
        if (r_cnt == CW'(CLK_DIV - 1)) begin
          w_cnt     = '0;
          w_adc_clk = ~r_adc_clk;
          w_shift   = ~r_adc_clk;
          w_half    = r_half + HW'(1);
          if (r_half == HW'(2 * FRAME_BITS - 1)) begin
            w_state = DONE;
            w_cs    = 1'b1;
            w_valid = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      DONE: w_state = QUIET;
      QUIET: begin
        w_state = r_cnt == CW'(QUIET_CYCLES - 1) ? IDLE : QUIET;
        w_ready = r_cnt == CW'(QUIET_CYCLES - 1);
        w_cnt   = r_cnt == CW'(QUIET_CYCLES - 1) ? '0 : r_cnt + CW'(1);
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_half    <= '0;
      r_sr1     <= '0;
      r_sr2     <= '0;
      r_adc_clk <= 1'b1;
      r_cs      <= 1'b1;
      r_d1      <= '0;
      r_d2      <= '0;
      r_valid   <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_half    <= w_half;
      r_adc_clk <= w_adc_clk;
      r_cs      <= w_cs;
      r_valid   <= w_valid;
      r_ready   <= w_ready;
      if (w_shift) begin
        r_sr1 <= w_cap1[SW-2:0];
        r_sr2 <= w_cap2[SW-2:0];
      end
      if (w_valid) begin
        r_d1 <= w_cap1[DATA_BITS-1:0];
        r_d2 <= w_cap2[DATA_BITS-1:0];
      end
    end
  end
`ifdef ADC_LEAD_CHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (!rst) r_err <= 1'b0;
    else if (w_valid) r_err <= (|w_cap1[FRAME_BITS-1:DATA_BITS]) | (|w_cap2[FRAME_BITS-1:DATA_BITS]);
  end
  assign frame_err = r_err;
`else
  assign frame_err = 1'b0;
`endif
  assign adc_clk   = r_adc_clk;
  assign chip_sel  = r_cs;
  assign data_out1 = r_d1;
  assign data_out2 = r_d2;
  assign valid     = r_valid;
  assign ready     = r_ready;
endmodule

// File: tb/tb_adc_reader.sv
// tb_adc_reader: drives two adc_reader instances (default timing and CLK_DIV=1/QUIET_CYCLES=1)
// from an ADC model and scores every frame against the expected sample, latency and handshake.
module tb_adc_reader;
  localparam int D = 12;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] go, di1, di2;
  wire  [1:0] ac, cs, vld, rdy, err;
  wire  [D-1:0] d1a, d2a, d1b, d2b;
  logic [15:0] fr1 [2][32];
  logic [15:0] fr2 [2][32];
  int nfr[2], cur[2], bi[2], rises[2], nvalid[2], vr[2], t0[2];
  bit pend[2];
  logic [1:0] pac, pcs, prdy;
  int cyc, nvec, nerr;
  always #5 clk = ~clk;
  adc_reader u_dut (
    .clk(clk), .rst(rst), .go(go[0]), .data_in1(di1[0]), .data_in2(di2[0]),
    .adc_clk(ac[0]), .chip_sel(cs[0]), .data_out1(d1a), .data_out2(d2a),
    .valid(vld[0]), .ready(rdy[0]), .frame_err(err[0])
  );
  adc_reader #(.CLK_DIV(1), .QUIET_CYCLES(1)) u_fast (
    .clk(clk), .rst(rst), .go(go[1]), .data_in1(di1[1]), .data_in2(di2[1]),
    .adc_clk(ac[1]), .chip_sel(cs[1]), .data_out1(d1b), .data_out2(d2b),
    .valid(vld[1]), .ready(rdy[1]), .frame_err(err[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // ADC model plus scoreboard: frames come from fr1/fr2 in start order, bits change on adc_clk falls.
  always @(negedge clk) begin
    logic [15:0] e1, e2;
    logic ee;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (pcs[i] && !cs[i]) begin
        if (nvalid[i] > 0) chk("quiet_gap", 32'(cyc - vr[i] >= (i == 0 ? 2 : 1)), 1);
        cur[i] = nfr[i];
        nfr[i]++;
        bi[i] = 0;
        rises[i] = 0;
        t0[i] = cyc;
      end
      if (!cs[i] && pac[i] && !ac[i] && bi[i] < 16) begin
        di1[i] = fr1[i][cur[i]][15 - bi[i]];
        di2[i] = fr2[i][cur[i]][15 - bi[i]];
        bi[i]++;
      end
      if (!pac[i] && ac[i]) rises[i]++;
      if (vld[i]) begin
        e1 = fr1[i][cur[i]];
        e2 = fr2[i][cur[i]];
`ifdef ADC_LEAD_CHECK_EN
        ee = (|e1[15:12]) | (|e2[15:12]);
`else
        ee = 1'b0;
`endif
        chk("latency", cyc - t0[i], i == 0 ? 132 : 33);
        chk("rises", rises[i], 16);
        chk("data1", i == 0 ? d1a : d1b, e1[11:0]);
        chk("data2", i == 0 ? d2a : d2b, e2[11:0]);
        chk("frame_err", err[i], ee);
        vr[i] = cyc;
        pend[i] = 1;
        nvalid[i]++;
      end
      if (pend[i] && rdy[i] && !prdy[i]) begin
        chk("ready_return", cyc - vr[i], i == 0 ? 3 : 2);
        pend[i] = 0;
      end
    end
    pac = ac;
    pcs = cs;
    prdy = rdy;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_done(input int i, input int n, input int budget);
    int t = 0;
    while (nvalid[i] <= n && t < budget) begin step(); t++; end
    chk("valid_seen", 32'(nvalid[i] > n), 1);
    while (!rdy[i] && t < budget) begin step(); t++; end
    chk("back_idle", rdy[i], 1);
  endtask
  task automatic frame(input int i, input logic [15:0] a, input logic [15:0] b);
    int n = nvalid[i];
    fr1[i][nfr[i]] = a;
    fr2[i][nfr[i]] = b;
    go[i] = 1'b1;
    step();
    go[i] = 1'b0;
    wait_done(i, n, 400);
  endtask
  initial begin
    int s, n, t;
    rst = 1'b0; go = '0; di1 = '0; di2 = '0;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_adc_clk", ac[i], 1);
      chk("rst_chip_sel", cs[i], 1);
      chk("rst_ready", rdy[i], 1);
      chk("rst_valid", vld[i], 0);
      chk("rst_frame_err", err[i], 0);
      chk("rst_data", i == 0 ? {d1a, d2a} : {d1b, d2b}, 0);
    end
    rst = 1'b1;
    step();
    frame(0, 16'h0ABC, 16'h0123);
    // go asserted on every cycle of a frame must still give one frame
    fr1[0][nfr[0]] = 16'($urandom); fr2[0][nfr[0]] = 16'($urandom);
    s = nfr[0]; n = nvalid[0]; t = 0;
    go[0] = 1'b1;
    while (nvalid[0] == n && t < 400) begin step(); t++; end
    go[0] = 1'b0;
    wait_done(0, n, 400);
    chk("single_frame", nfr[0] - s, 1);
    chk("single_valid", nvalid[0] - n, 1);
    // go held high: three back-to-back frames
    fr1[0][nfr[0]] = 16'h0FFF; fr2[0][nfr[0]] = 16'h0000;
    fr1[0][nfr[0]+1] = 16'h0000; fr2[0][nfr[0]+1] = 16'h0FFF;
    fr1[0][nfr[0]+2] = 16'h0555; fr2[0][nfr[0]+2] = 16'h0AAA;
    s = nfr[0]; n = nvalid[0]; t = 0;
    go[0] = 1'b1;
    while (nvalid[0] < n + 3 && t < 1500) begin step(); t++; end
    go[0] = 1'b0;
    wait_done(0, n + 2, 400);
    chk("held_frames", nfr[0] - s, 3);
    // reset at the 8th adc_clk rise discards the partial frame
    fr1[0][nfr[0]] = 16'h0F0F; fr2[0][nfr[0]] = 16'h0777;
    n = nvalid[0]; t = 0;
    go[0] = 1'b1;
    step();
    go[0] = 1'b0;
    while (rises[0] < 8 && t < 400) begin step(); t++; end
    chk("reached_rise8", rises[0], 8);
    rst = 1'b0;
    step();
    chk("abort_chip_sel", cs[0], 1);
    chk("abort_adc_clk", ac[0], 1);
    chk("abort_ready", rdy[0], 1);
    chk("abort_data", {d1a, d2a}, 0);
    rst = 1'b1;
    step();
    chk("abort_no_valid", nvalid[0] - n, 0);
    frame(0, 16'h0321, 16'($urandom));
    frame(1, 16'h0FFF, 16'h0001);
    frame(0, 16'h8ABC, 16'h0123);
    frame(0, 16'h0ABC, 16'h0123);
    for (int k = 0; k < 5; k++) frame(0, 16'($urandom), 16'($urandom));
    for (int k = 0; k < 8; k++) frame(1, 16'($urandom), 16'($urandom));
    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
